skeleton_frame_streamer: RTL and testbench
==========================================

// Module: skeleton_frame_streamer
// PURPOSE
//  Reads a stored frame (1-bit skeleton mask + per-pixel model-distance map) from dual BRAM ports.
//  Replays it as a raster pixel stream: hcount/vcount/skeleton_bit/pixel_distance/valid.
//  This stream is the input to the pose scorer.
//  Sits between the distance-transform frame buffers and the scorer.
//  Supports valid/ready backpressure. The scorer has no ready, so it ties ready_in=1.
//  With ready_in=1 the stream is gap-free at 1 pixel/clk.
// PARAMETERS
//  HRES          320  pixels per line
//  VRES          180  lines per frame
//  BRAM_LATENCY  2    cycles from addr_out to *_rd_in data
//  CLAMP_MAX     31   saturation value for pixel_distance_out (STREAMER_CLAMP_EN only)
//  derived: HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES), DWIDTH=$clog2(HRES+VRES+1),
//           AWIDTH=$clog2(HRES*VRES), DEPTH=BRAM_LATENCY+1 (output FIFO entries)
// PORTS
//  clk_in              in   1       system clock
//  rst_in              in   1       synchronous reset, active-low
//  start_in            in   1       1-cycle pulse: stream one frame
//  busy_out            out  1       high from start acceptance until done_out
//  done_out            out  1       1-cycle pulse after last pixel handshake
//  addr_out            out  AWIDTH  BRAM read address, = vcount*HRES+hcount
//  skel_rd_in          in   1       skeleton-mask BRAM data
//  dist_rd_in          in   DWIDTH  distance-map BRAM data
//  ready_in            in   1       downstream accepts pixel
//  valid_out           out  1       pixel fields valid
//  hcount_out          out  HWIDTH  pixel column
//  vcount_out          out  VWIDTH  pixel row
//  skeleton_bit_out    out  1       mask bit of pixel
//  pixel_distance_out  out  DWIDTH  distance of pixel
// BEHAVIOUR
//  Reset (rst_in==0 at posedge) clears state to IDLE and all counters, credits and FIFO.
//    Outputs: valid/busy/done=0, addr/hcount/vcount/skel/dist=0.
//  In-flight BRAM reads are discarded. Reset mid-frame aborts the frame; no done_out.
//  FSM states: IDLE, ISSUE, DRAIN, DONE.
//  IDLE: start_in=1 -> ISSUE, busy_out=1, read pointer (rh,rv)=(0,0). start_in while busy is ignored.
//  ISSUE: issue one read per cycle while (fifo_count + inflight - pop) < DEPTH.
//    addr_out registered; read pointer advances rh 0..HRES-1, then rv++.
//    (rh,rv) travels down a BRAM_LATENCY-deep tag pipe aligned with the read data.
//    Issuing (HRES-1,VRES-1) -> DRAIN.
//  DRAIN: no new reads. Wait until inflight==0 and FIFO empty -> DONE.
//  DONE: done_out=1 for one cycle, busy_out=0 -> IDLE.
//  FIFO: push when tag pipe emits; never overflows by credit rule (assertion).
//    valid_out = FIFO non-empty. Fields are the FIFO head.
//    Pop on valid_out&&ready_in. Push and pop in the same cycle are both honoured.
//  Handshake: once valid_out=1, it and all fields hold stable until ready_in=1.
//  Latency: start_in sampled at cycle 0 -> addr_out=0 at cycle 1 -> valid_out=1 at cycle BRAM_LATENCY+2.
//  Throughput with ready_in=1: one pixel/clk, no bubbles. Last pixel at cycle HRES*VRES+BRAM_LATENCY+1.
//    done_out is on the following cycle.
//  Pixels are emitted strictly in raster order; hcount wraps HRES-1 -> 0 with vcount+1.
//  Widths: addr computed by incremental counter (+1 per issue), not a multiplier.
//    addr wraps to 0 only on a new start.
// CONFIGURATION
//  STREAMER_CLAMP_EN defined:
//    pixel_distance_out = min(dist, CLAMP_MAX).
//    The clamp is applied at FIFO push; the stored width stays DWIDTH, upper bits zero.
//  Undefined: pixel_distance_out = raw dist_rd_in value, unmodified.
// TESTING (bench uses HRES=4, VRES=3, BRAM_LATENCY=2, behavioural BRAM model)
//  1. Reset, start pulse, ready=1, dist[a]=a.
//     -> valid_out rises at cycle 4; 12 contiguous pixels (h,v)=(0,0)..(3,2), dist 0..11.
//     -> done_out at cycle 16.
//  2. ready_in toggles 1,0,1,0... -> all 12 pixels in order exactly once.
//     Fields stable while ready=0; FIFO never exceeds 3.
//  3. ready_in=0 for 20 cycles after start -> addr_out stops after 3 issues.
//     Ready=1 then resumes with no loss or duplication.
//  4. Second start_in mid-frame -> ignored; exactly 12 pixels and one done_out.
//  5. rst_in=0 at pixel 5 -> next cycle valid/busy=0.
//     A new start then streams from (0,0) with no stale data.
//  6. dist[a]=100 at all a: STREAMER_CLAMP_EN -> output 31; undefined -> output 100.

Source files
------------

// File: rtl/skeleton_frame_streamer_if.sv
// Raster pixel stream from the skeleton frame streamer to the pose scorer,
// a valid/ready channel that carries the pixel coordinates, mask bit and distance.
interface skeleton_frame_streamer_if #(
  parameter int HWIDTH = 9,
  parameter int VWIDTH = 8,
  parameter int DWIDTH = 9
);
  logic              valid_out;
  logic              ready_in;
  logic [HWIDTH-1:0] hcount_out;
  logic [VWIDTH-1:0] vcount_out;
  logic              skeleton_bit_out;
  logic [DWIDTH-1:0] pixel_distance_out;

  modport master (
    output valid_out, hcount_out, vcount_out, skeleton_bit_out, pixel_distance_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, hcount_out, vcount_out, skeleton_bit_out, pixel_distance_out,
    output ready_in
  );
endinterface

// File: rtl/skeleton_frame_streamer.sv
// Replays a stored skeleton mask + distance frame from BRAM as a raster pixel stream.
// Optional feature macro: STREAMER_CLAMP_EN saturates pixel_distance_out at CLAMP_MAX.
module skeleton_frame_streamer #(
  parameter int HRES         = 320,
  parameter int VRES         = 180,
  parameter int BRAM_LATENCY = 2,
  parameter int CLAMP_MAX    = 31,
  parameter int DWIDTH       = $clog2(HRES + VRES + 1),
  localparam int HWIDTH      = $clog2(HRES),
  localparam int VWIDTH      = $clog2(VRES),
  localparam int AWIDTH      = $clog2(HRES * VRES)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [AWIDTH-1:0]         addr_out,
  input  logic                      skel_rd_in,
  input  logic [DWIDTH-1:0]         dist_rd_in,
  skeleton_frame_streamer_if.master pix
);

  localparam int LAT   = BRAM_LATENCY;
  localparam int DEPTH = BRAM_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [HWIDTH-1:0]            rh_q, rh_d;
  logic [VWIDTH-1:0]            rv_q, rv_d;
  logic [AWIDTH-1:0]            addr_q, addr_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [LAT-1:0]               tag_vld_q, tag_vld_d;
  logic [LAT-1:0][HWIDTH-1:0]   tag_h_q, tag_h_d;
  logic [LAT-1:0][VWIDTH-1:0]   tag_v_q, tag_v_d;
  logic [DEPTH-1:0][HWIDTH-1:0] fifo_h_q, fifo_h_d;
  logic [DEPTH-1:0][VWIDTH-1:0] fifo_v_q, fifo_v_d;
  logic [DEPTH-1:0]             fifo_s_q, fifo_s_d;
  logic [DEPTH-1:0][DWIDTH-1:0] fifo_d_q, fifo_d_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              last_s;
  logic [DWIDTH-1:0] push_dist_s;
  int                inflight_s;
  int                credit_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Distance value written into the FIFO, saturated when clamping is built in
  always_comb begin
`ifdef STREAMER_CLAMP_EN
    if (int'(dist_rd_in) > CLAMP_MAX) begin
      push_dist_s = DWIDTH'(CLAMP_MAX);
    end else begin
      push_dist_s = dist_rd_in;
    end
`else
    push_dist_s = dist_rd_in;
`endif
  end

  // Next-state, read issue with credit check, tag pipe and FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    rh_d      = rh_q;
    rv_d      = rv_q;
    addr_d    = addr_q;
    tag_vld_d = tag_vld_q;
    tag_h_d   = tag_h_q;
    tag_v_d   = tag_v_q;
    fifo_h_d  = fifo_h_q;
    fifo_v_d  = fifo_v_q;
    fifo_s_d  = fifo_s_q;
    fifo_d_d  = fifo_d_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    issue_s   = 1'b0;

    last_s     = (rh_q == HWIDTH'(HRES - 1)) && (rv_q == VWIDTH'(VRES - 1));
    pop_s      = (count_q != '0) && pix.ready_in;
    push_s     = tag_vld_q[LAT-1];
    inflight_s = $countones(tag_vld_q);
    // Every read already in the tag pipe owns a FIFO slot before it is issued
    credit_s   = int'(count_q) + inflight_s - int'(pop_s);
    count_d    = count_q + CW'(push_s) - CW'(pop_s);

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ISSUE;
          rh_d    = '0;
          rv_d    = '0;
          addr_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (credit_s < DEPTH) begin
          issue_s = 1'b1;
          if (last_s) begin
            state_d = DRAIN;
          end else if (rh_q == HWIDTH'(HRES - 1)) begin
            rh_d   = '0;
            rv_d   = rv_q + VWIDTH'(1);
            addr_d = addr_q + AWIDTH'(1);
          end else begin
            rh_d   = rh_q + HWIDTH'(1);
            addr_d = addr_q + AWIDTH'(1);
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if ((inflight_s == int'(push_s)) && (count_d == '0)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tag_vld_d[0] = issue_s;
    tag_h_d[0]   = rh_q;
    tag_v_d[0]   = rv_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_h_d[i]   = tag_h_q[i-1];
      tag_v_d[i]   = tag_v_q[i-1];
    end

    if (push_s) begin
      fifo_h_d[wr_ptr_q] = tag_h_q[LAT-1];
      fifo_v_d[wr_ptr_q] = tag_v_q[LAT-1];
      fifo_s_d[wr_ptr_q] = skel_rd_in;
      fifo_d_d[wr_ptr_q] = push_dist_s;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State, counters, tag pipe and FIFO registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      rh_q      <= '0;
      rv_q      <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_h_q   <= '0;
      tag_v_q   <= '0;
      fifo_h_q  <= '0;
      fifo_v_q  <= '0;
      fifo_s_q  <= '0;
      fifo_d_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rh_q      <= rh_d;
      rv_q      <= rv_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tag_vld_q <= tag_vld_d;
      tag_h_q   <= tag_h_d;
      tag_v_q   <= tag_v_d;
      fifo_h_q  <= fifo_h_d;
      fifo_v_q  <= fifo_v_d;
      fifo_s_q  <= fifo_s_d;
      fifo_d_q  <= fifo_d_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign addr_out = addr_q;

  // Fields read as zero whenever no pixel is presented
  assign pix.valid_out          = (count_q != '0);
  assign pix.hcount_out         = pix.valid_out ? fifo_h_q[rd_ptr_q] : '0;
  assign pix.vcount_out         = pix.valid_out ? fifo_v_q[rd_ptr_q] : '0;
  assign pix.skeleton_bit_out   = pix.valid_out ? fifo_s_q[rd_ptr_q] : 1'b0;
  assign pix.pixel_distance_out = pix.valid_out ? fifo_d_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_skeleton_frame_streamer.sv
// Directed bench for skeleton_frame_streamer on a 4x3 frame with a 2-cycle BRAM model.
module tb_skeleton_frame_streamer;
  localparam int HRES = 4;
  localparam int VRES = 3;
  localparam int NPIX = 12;
  localparam int DW   = 8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic       busy_out;
  logic       done_out;
  logic [3:0] addr_out;
  logic       skel_rd_in;
  logic [7:0] dist_rd_in;

  int total = 0;
  int bad   = 0;

  logic       skel_mem [16];
  logic [7:0] dist_mem [16];
  int         exp_dist [NPIX];
  logic [3:0] a1, a2;

  skeleton_frame_streamer_if #(.HWIDTH(2), .VWIDTH(2), .DWIDTH(DW)) pix ();

  skeleton_frame_streamer #(
    .HRES(HRES), .VRES(VRES), .BRAM_LATENCY(2), .CLAMP_MAX(31), .DWIDTH(DW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out), .addr_out(addr_out),
    .skel_rd_in(skel_rd_in), .dist_rd_in(dist_rd_in), .pix(pix)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural BRAM: data for the address of cycle t appears in cycle t+2
  always @(posedge clk_in) begin
    a1 <= addr_out;
    a2 <= a1;
  end
  assign skel_rd_in = skel_mem[a2];
  assign dist_rd_in = dist_mem[a2];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready=1, 1: ready toggles, 2: ready low 20 cycles, 3: extra start pulses
  task automatic run_frame(input int mode);
    int         idx, dones, first_v, done_cyc;
    logic       pvld, prdy, ps;
    logic [1:0] ph, pv;
    logic [7:0] pd;
    idx = 0; dones = 0; first_v = -1; done_cyc = -1;
    pvld = 1'b0; prdy = 1'b1; ph = '0; pv = '0; pd = '0; ps = 1'b0;
    start_in     = 1'b1;
    pix.ready_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      case (mode)
        1:       pix.ready_in = cyc[0];
        2:       pix.ready_in = (cyc > 20);
        default: pix.ready_in = 1'b1;
      endcase
      start_in = (mode == 3) && (cyc == 5 || cyc == 9);
      if (mode == 2 && cyc == 20) begin
        chk("stall_addr", addr_out, 32'd3);
        chk("stall_valid", pix.valid_out, 32'd1);
      end
      if (mode == 0) chk("gapfree_valid", pix.valid_out, (cyc >= 4 && cyc <= 15));
      if (pvld && !prdy) begin
        chk("hold_valid", pix.valid_out, 32'd1);
        chk("hold_h", pix.hcount_out, ph);
        chk("hold_v", pix.vcount_out, pv);
        chk("hold_skel", pix.skeleton_bit_out, ps);
        chk("hold_dist", pix.pixel_distance_out, pd);
      end
      if (pix.valid_out && first_v < 0) first_v = cyc;
      if (pix.valid_out && pix.ready_in) begin
        chk("pix_h", pix.hcount_out, idx % HRES);
        chk("pix_v", pix.vcount_out, idx / HRES);
        chk("pix_skel", pix.skeleton_bit_out, ((idx % 3) == 0));
        chk("pix_dist", pix.pixel_distance_out, exp_dist[idx % NPIX]);
        idx++;
      end
      if (done_out) begin
        dones++;
        done_cyc = cyc;
        chk("done_busy", busy_out, 32'd0);
        chk("done_idx", idx, NPIX);
      end
      pvld = pix.valid_out; prdy = pix.ready_in;
      ph = pix.hcount_out; pv = pix.vcount_out;
      ps = pix.skeleton_bit_out; pd = pix.pixel_distance_out;
      tick();
      if (dones != 0) break;
    end
    start_in = 1'b0;
    chk("frame_pixels", idx, NPIX);
    chk("frame_dones", dones, 32'd1);
    if (mode == 0) begin
      chk("first_valid_cyc", first_v, 32'd4);
      chk("done_cyc", done_cyc, 32'd16);
    end
    chk("after_valid", pix.valid_out, 32'd0);
    chk("after_busy", busy_out, 32'd0);
    chk("after_done", done_out, 32'd0);
    tick();
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      skel_mem[a] = ((a % 3) == 0);
      dist_mem[a] = 8'(a);
    end
    for (int i = 0; i < NPIX; i++) exp_dist[i] = i;
    rst_in = 1'b0; start_in = 1'b0; pix.ready_in = 1'b1;
    tick();
    tick();
    chk("rst_valid", pix.valid_out, 32'd0);
    chk("rst_busy", busy_out, 32'd0);
    chk("rst_done", done_out, 32'd0);
    chk("rst_addr", addr_out, 32'd0);
    chk("rst_h", pix.hcount_out, 32'd0);
    chk("rst_dist", pix.pixel_distance_out, 32'd0);
    rst_in = 1'b1;
    tick();

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);

    // Reset while pixel 5 is presented, then a clean frame from (0,0)
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("r5_addr0", addr_out, 32'd0);
    chk("r5_busy", busy_out, 32'd1);
    for (int c = 1; c < 9; c++) tick();
    chk("r5_head_h", pix.hcount_out, 32'd1);
    chk("r5_head_v", pix.vcount_out, 32'd1);
    rst_in = 1'b0;
    tick();
    chk("r5_valid", pix.valid_out, 32'd0);
    chk("r5_busy_lo", busy_out, 32'd0);
    chk("r5_addr", addr_out, 32'd0);
    rst_in = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("r5_idle_valid", pix.valid_out, 32'd0);
    chk("r5_idle_done", done_out, 32'd0);
    run_frame(0);

    for (int a = 0; a < 16; a++) dist_mem[a] = 8'd100;
`ifdef STREAMER_CLAMP_EN
    for (int i = 0; i < NPIX; i++) exp_dist[i] = 31;
`else
    for (int i = 0; i < NPIX; i++) exp_dist[i] = 100;
`endif
    run_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
